spell_mem_ctrl: RTL and testbench

- Memory access sequencer upstream of the spell memory/IO block.
- Arbitrates the CPU instruction-fetch port and the load/store port onto the single memory request interface (select/addr/data_in/memory_type_data/write in, data_out/data_ready back).
- Holds each access until the memory reports ready, returns the read data, and recovers from hung accesses via a timeout.

---
 rtl/spell_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_spell_mem_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_mem_ctrl.sv
// Memory access sequencer: arbitrates instruction fetch and load/store onto one memory port.
// Optional one-entry code prefetch buffer enabled by defining SPELL_MEM_CTRL_PREFETCH_EN.
module spell_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_req,
  input  logic [7:0] fetch_addr,
  output logic       fetch_ack,
  output logic [7:0] fetch_data,
  input  logic       ls_req,
  input  logic       ls_write,
  input  logic       ls_code,
  input  logic [7:0] ls_addr,
  input  logic [7:0] ls_wdata,
  output logic       ls_ack,
  output logic [7:0] ls_rdata,
  output logic       timeout_err,
  output logic       busy,
  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic       mem_type_data,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
  typedef enum logic [1:0] {OWN_FETCH, OWN_LS, OWN_PF} owner_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_reg, state_next;
  owner_t     owner_reg, owner_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       mem_select_reg, mem_select_next;
  logic [7:0] mem_addr_reg, mem_addr_next;
  logic [7:0] mem_data_in_reg, mem_data_in_next;
  logic       mem_type_data_reg, mem_type_data_next;
  logic       mem_write_reg, mem_write_next;
  logic [7:0] fetch_data_reg, fetch_data_next;
  logic [7:0] ls_rdata_reg, ls_rdata_next;
  logic       fetch_ack_reg, fetch_ack_next;
  logic       ls_ack_reg, ls_ack_next;
  logic       timeout_err_reg, timeout_err_next;

  logic       timeout_hit;
  logic       pf_hit;
  logic [7:0] pf_hit_data;
  logic       pf_start;
  logic [7:0] pf_fetch_addr;

`ifdef SPELL_MEM_CTRL_PREFETCH_EN
  logic       pf_valid_reg, pf_valid_next;
  logic [7:0] pf_addr_reg, pf_addr_next;
  logic [7:0] pf_data_reg, pf_data_next;
  logic       pf_pending_reg, pf_pending_next;
  logic [7:0] pf_next_addr_reg, pf_next_addr_next;

  assign pf_hit        = pf_valid_reg && (pf_addr_reg == fetch_addr);
  assign pf_hit_data   = pf_data_reg;
  assign pf_start      = pf_pending_reg;
  assign pf_fetch_addr = pf_next_addr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_valid_reg     <= 1'b0;
      pf_addr_reg      <= 8'h00;
      pf_data_reg      <= 8'h00;
      pf_pending_reg   <= 1'b0;
      pf_next_addr_reg <= 8'h00;
    end else begin
      pf_valid_reg     <= pf_valid_next;
      pf_addr_reg      <= pf_addr_next;
      pf_data_reg      <= pf_data_next;
      pf_pending_reg   <= pf_pending_next;
      pf_next_addr_reg <= pf_next_addr_next;
    end
  end
`else
  assign pf_hit        = 1'b0;
  assign pf_hit_data   = 8'h00;
  assign pf_start      = 1'b0;
  assign pf_fetch_addr = 8'h00;
`endif

  assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; load/store outranks fetch, fetch outranks speculation
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (ls_req) begin
          state_next = ST_ACCESS;
        end else if (fetch_req) begin
          state_next = pf_hit ? ST_DONE : ST_ACCESS;
        end else if (pf_start) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_data_ready || timeout_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    owner_next         = owner_reg;
    cnt_next           = cnt_reg;
    mem_select_next    = mem_select_reg;
    mem_addr_next      = mem_addr_reg;
    mem_data_in_next   = mem_data_in_reg;
    mem_type_data_next = mem_type_data_reg;
    mem_write_next     = mem_write_reg;
    fetch_data_next    = fetch_data_reg;
    ls_rdata_next      = ls_rdata_reg;
    fetch_ack_next     = 1'b0;
    ls_ack_next        = 1'b0;
    timeout_err_next   = 1'b0;
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
    pf_valid_next      = pf_valid_reg;
    pf_addr_next       = pf_addr_reg;
    pf_data_next       = pf_data_reg;
    pf_pending_next    = pf_pending_reg;
    pf_next_addr_next  = pf_next_addr_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        cnt_next = 8'h00;
        if (ls_req) begin
          owner_next         = OWN_LS;
          mem_select_next    = 1'b1;
          mem_addr_next      = ls_addr;
          mem_type_data_next = ~ls_code;
          mem_write_next     = ls_write;
          mem_data_in_next   = ls_wdata;
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
          // Program upload may overwrite the buffered byte
          if (ls_code && ls_write) begin
            pf_valid_next = 1'b0;
          end
`endif
        end else if (fetch_req) begin
          if (pf_hit) begin
            fetch_ack_next  = 1'b1;
            fetch_data_next = pf_hit_data;
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
            pf_pending_next   = 1'b1;
            pf_next_addr_next = fetch_addr + 8'd1;
`endif
          end else begin
            owner_next         = OWN_FETCH;
            mem_select_next    = 1'b1;
            mem_addr_next      = fetch_addr;
            mem_type_data_next = 1'b0;
            mem_write_next     = 1'b0;
          end
        end else if (pf_start) begin
          owner_next         = OWN_PF;
          mem_select_next    = 1'b1;
          mem_addr_next      = pf_fetch_addr;
          mem_type_data_next = 1'b0;
          mem_write_next     = 1'b0;
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
          pf_pending_next    = 1'b0;
`endif
        end
      end
      ST_ACCESS: begin
        if (mem_data_ready) begin
          mem_select_next = 1'b0;
          case (owner_reg)
            OWN_FETCH: begin
              fetch_data_next = mem_data_out;
              fetch_ack_next  = 1'b1;
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
              pf_pending_next   = 1'b1;
              pf_next_addr_next = mem_addr_reg + 8'd1;
`endif
            end
            OWN_LS: begin
              if (!mem_write_reg) begin
                ls_rdata_next = mem_data_out;
              end
              ls_ack_next = 1'b1;
            end
            default: begin
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
              pf_valid_next = 1'b1;
              pf_addr_next  = mem_addr_reg;
              pf_data_next  = mem_data_out;
`endif
            end
          endcase
        end else if (timeout_hit) begin
          // Aborted reads return all-ones so software can spot them
          mem_select_next = 1'b0;
          case (owner_reg)
            OWN_FETCH: begin
              fetch_data_next  = 8'hFF;
              fetch_ack_next   = 1'b1;
              timeout_err_next = 1'b1;
            end
            OWN_LS: begin
              if (!mem_write_reg) begin
                ls_rdata_next = 8'hFF;
              end
              ls_ack_next      = 1'b1;
              timeout_err_next = 1'b1;
            end
            default: begin
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
              pf_valid_next = 1'b0;
`endif
            end
          endcase
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg         <= OWN_FETCH;
      cnt_reg           <= 8'h00;
      mem_select_reg    <= 1'b0;
      mem_addr_reg      <= 8'h00;
      mem_data_in_reg   <= 8'h00;
      mem_type_data_reg <= 1'b0;
      mem_write_reg     <= 1'b0;
      fetch_data_reg    <= 8'h00;
      ls_rdata_reg      <= 8'h00;
      fetch_ack_reg     <= 1'b0;
      ls_ack_reg        <= 1'b0;
      timeout_err_reg   <= 1'b0;
    end else begin
      owner_reg         <= owner_next;
      cnt_reg           <= cnt_next;
      mem_select_reg    <= mem_select_next;
      mem_addr_reg      <= mem_addr_next;
      mem_data_in_reg   <= mem_data_in_next;
      mem_type_data_reg <= mem_type_data_next;
      mem_write_reg     <= mem_write_next;
      fetch_data_reg    <= fetch_data_next;
      ls_rdata_reg      <= ls_rdata_next;
      fetch_ack_reg     <= fetch_ack_next;
      ls_ack_reg        <= ls_ack_next;
      timeout_err_reg   <= timeout_err_next;
    end
  end

  assign busy          = (state_reg != ST_IDLE);
  assign mem_select    = mem_select_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_data_in   = mem_data_in_reg;
  assign mem_type_data = mem_type_data_reg;
  assign mem_write     = mem_write_reg;
  assign fetch_data    = fetch_data_reg;
  assign ls_rdata      = ls_rdata_reg;
  assign fetch_ack     = fetch_ack_reg;
  assign ls_ack        = ls_ack_reg;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_spell_mem_ctrl.sv
// Directed bench for spell_mem_ctrl: fetch, priority, wait states, timeout, reset, prefetch.
module tb_spell_mem_ctrl;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic       ls_req, ls_write, ls_code;
  logic [7:0] ls_addr, ls_wdata;
  logic       ls_ack;
  logic [7:0] ls_rdata;
  logic       timeout_err, busy;
  logic       mem_select;
  logic [7:0] mem_addr, mem_data_in;
  logic       mem_type_data, mem_write;
  logic [7:0] mem_data_out;
  logic       mem_data_ready;

  int vec_count = 0;
  int err_count = 0;

  // Memory responder: ready after wait_cfg extra select cycles
  logic [7:0]  wait_cfg = 8'd0;
  logic [7:0]  rd_val = 8'h00;
  logic [7:0]  sel_cnt = 8'd0;
  int          sel_cycles = 0;
  logic        prev_sel = 1'b0;
  logic [17:0] held = '0;
  logic        unstable = 1'b0;

  assign mem_data_ready = mem_select && (sel_cnt == wait_cfg);
  assign mem_data_out   = rd_val;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_select) begin
      sel_cnt    <= sel_cnt + 8'd1;
      sel_cycles <= sel_cycles + 1;
    end else begin
      sel_cnt <= 8'd0;
    end
    if (mem_select && prev_sel && ({mem_addr, mem_data_in, mem_type_data, mem_write} != held))
      unstable <= 1'b1;
    prev_sel <= mem_select;
    held     <= {mem_addr, mem_data_in, mem_type_data, mem_write};
  end

  spell_mem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
    .ls_req(ls_req), .ls_write(ls_write), .ls_code(ls_code), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata), .timeout_err(timeout_err), .busy(busy),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_type_data(mem_type_data), .mem_write(mem_write),
    .mem_data_out(mem_data_out), .mem_data_ready(mem_data_ready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_req = 0; fetch_addr = 0; ls_req = 0; ls_write = 0; ls_code = 0;
    ls_addr = 0; ls_wdata = 0;
    tick(); tick();
    vec_count++;
    if ({fetch_ack, ls_ack, timeout_err, busy, mem_select, mem_type_data, mem_write} !== 7'b0 ||
        {mem_addr, mem_data_in, fetch_data, ls_rdata} !== 32'h0) begin
      err_count++;
      $display("FAIL reset_hold: outputs %b %h required all zero",
               {fetch_ack, ls_ack, timeout_err, busy, mem_select, mem_type_data, mem_write},
               {mem_addr, mem_data_in, fetch_data, ls_rdata});
    end
    rst = 1'b0;
    tick(); tick();
    vec_count++;
    if ({busy, mem_select, fetch_ack, ls_ack} !== 4'b0) begin
      err_count++;
      $display("FAIL reset_release: busy/sel/acks %b required 0000", {busy, mem_select, fetch_ack, ls_ack});
    end
    $display("reset: done");
  endtask

  task automatic test_fetch_zero_wait();
    int s0;
    s0 = sel_cycles;
    wait_cfg = 8'd0; rd_val = 8'hA5;
    fetch_addr = 8'h10; fetch_req = 1'b1;
    tick();
    vec_count++;
    if ({mem_select, mem_addr, mem_type_data, mem_write, busy, fetch_ack} !== {1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      err_count++;
      $display("FAIL fetch_select: sel=%b addr=%h type=%b wr=%b busy=%b ack=%b required 1 10 0 0 1 0",
               mem_select, mem_addr, mem_type_data, mem_write, busy, fetch_ack);
    end
    tick();
    vec_count++;
    if ({fetch_ack, fetch_data, mem_select} !== {1'b1, 8'hA5, 1'b0}) begin
      err_count++;
      $display("FAIL fetch_ack: ack=%b data=%h sel=%b required 1 a5 0", fetch_ack, fetch_data, mem_select);
    end
    fetch_req = 1'b0;
    tick();
    vec_count++;
    if ({fetch_ack, busy} !== 2'b00 || (sel_cycles - s0) != 1) begin
      err_count++;
      $display("FAIL fetch_after: ack=%b busy=%b selcycles=%0d required 0 0 1", fetch_ack, busy, sel_cycles - s0);
    end
    $display("fetch 10 -> %h", fetch_data);
  endtask

  task automatic test_priority();
    wait_cfg = 8'd0; rd_val = 8'h5A;
    ls_req = 1'b1; ls_write = 1'b0; ls_code = 1'b0; ls_addr = 8'h40;
    fetch_req = 1'b1; fetch_addr = 8'h22;
    tick();
    vec_count++;
    if ({mem_select, mem_addr, mem_type_data, mem_write} !== {1'b1, 8'h40, 1'b1, 1'b0}) begin
      err_count++;
      $display("FAIL prio_first: sel=%b addr=%h type=%b wr=%b required 1 40 1 0",
               mem_select, mem_addr, mem_type_data, mem_write);
    end
    tick();
    vec_count++;
    if ({ls_ack, fetch_ack, ls_rdata, mem_select} !== {1'b1, 1'b0, 8'h5A, 1'b0}) begin
      err_count++;
      $display("FAIL prio_lsack: lsack=%b fack=%b rdata=%h sel=%b required 1 0 5a 0",
               ls_ack, fetch_ack, ls_rdata, mem_select);
    end
    ls_req = 1'b0;
    tick();
    vec_count++;
    if ({mem_select, busy} !== 2'b00) begin
      err_count++;
      $display("FAIL prio_gap: sel=%b busy=%b required 0 0", mem_select, busy);
    end
    tick();
    vec_count++;
    if ({mem_select, mem_addr, mem_type_data} !== {1'b1, 8'h22, 1'b0}) begin
      err_count++;
      $display("FAIL prio_fetch: sel=%b addr=%h type=%b required 1 22 0", mem_select, mem_addr, mem_type_data);
    end
    tick();
    vec_count++;
    if ({fetch_ack, fetch_data} !== {1'b1, 8'h5A}) begin
      err_count++;
      $display("FAIL prio_fack: ack=%b data=%h required 1 5a", fetch_ack, fetch_data);
    end
    fetch_req = 1'b0;
    tick();
    $display("priority: load 40 then fetch 22");
  endtask

  task automatic test_wait_store();
    int s0;
    int bad;
    s0 = sel_cycles; bad = 0;
    wait_cfg = 8'd4; rd_val = 8'hEE;
    ls_req = 1'b1; ls_write = 1'b1; ls_code = 1'b0; ls_addr = 8'h05; ls_wdata = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({mem_select, mem_write, mem_data_in, mem_type_data, mem_addr, ls_ack} !== {1'b1, 1'b1, 8'h3C, 1'b1, 8'h05, 1'b0})
        bad++;
    end
    vec_count++;
    if (bad != 0) begin
      err_count++;
      $display("FAIL store_hold: %0d select cycles wrong, required 5 stable cycles", bad);
    end
    tick();
    vec_count++;
    if ({ls_ack, mem_select, ls_rdata} !== {1'b1, 1'b0, 8'h5A}) begin
      err_count++;
      $display("FAIL store_ack: ack=%b sel=%b rdata=%h required 1 0 5a", ls_ack, mem_select, ls_rdata);
    end
    ls_req = 1'b0; ls_write = 1'b0;
    tick();
    vec_count++;
    if (ls_ack !== 1'b0 || (sel_cycles - s0) != 5 || unstable !== 1'b0) begin
      err_count++;
      $display("FAIL store_after: ack=%b selcycles=%0d unstable=%b required 0 5 0", ls_ack, sel_cycles - s0, unstable);
    end
    $display("store 3c -> 05");
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    wait_cfg = 8'd255; rd_val = 8'h77;
    ls_req = 1'b1; ls_write = 1'b0; ls_code = 1'b0; ls_addr = 8'h33;
    for (int i = 0; i < TO; i++) begin
      tick();
      if ({mem_select, ls_ack, timeout_err} !== 3'b100) bad++;
    end
    vec_count++;
    if (bad != 0) begin
      err_count++;
      $display("FAIL timeout_window: %0d cycles wrong, required select for %0d cycles", bad, TO);
    end
    tick();
    vec_count++;
    if ({mem_select, ls_ack, timeout_err, ls_rdata, busy} !== {1'b0, 1'b1, 1'b1, 8'hFF, 1'b1}) begin
      err_count++;
      $display("FAIL timeout_ack: sel=%b ack=%b err=%b rdata=%h busy=%b required 0 1 1 ff 1",
               mem_select, ls_ack, timeout_err, ls_rdata, busy);
    end
    ls_req = 1'b0;
    tick();
    vec_count++;
    if ({busy, timeout_err, ls_ack} !== 3'b000) begin
      err_count++;
      $display("FAIL timeout_after: busy=%b err=%b ack=%b required 000", busy, timeout_err, ls_ack);
    end
    $display("timeout load 33 -> %h", ls_rdata);
  endtask

  task automatic test_ready_at_timeout();
    wait_cfg = 8'(TO - 1); rd_val = 8'h6B;
    ls_req = 1'b1; ls_write = 1'b0; ls_code = 1'b0; ls_addr = 8'h34;
    for (int i = 0; i < TO + 1; i++) tick();
    vec_count++;
    if ({ls_ack, timeout_err, ls_rdata} !== {1'b1, 1'b0, 8'h6B}) begin
      err_count++;
      $display("FAIL ready_at_timeout: ack=%b err=%b rdata=%h required 1 0 6b", ls_ack, timeout_err, ls_rdata);
    end
    ls_req = 1'b0;
    tick();
    $display("ready on timeout cycle -> %h", ls_rdata);
  endtask

  task automatic test_reset_mid();
    logic saw;
    saw = 1'b0;
    wait_cfg = 8'd255; rd_val = 8'h12;
    fetch_addr = 8'h50; fetch_req = 1'b1;
    tick(); tick();
    vec_count++;
    if (mem_select !== 1'b1) begin
      err_count++;
      $display("FAIL rstmid_pre: sel=%b required 1", mem_select);
    end
    #2 rst = 1'b1;
    #1;
    vec_count++;
    if ({mem_select, busy} !== 2'b00) begin
      err_count++;
      $display("FAIL rstmid_async: sel=%b busy=%b required 0 0", mem_select, busy);
    end
    fetch_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      saw = saw | fetch_ack | ls_ack | timeout_err | mem_select;
    end
    vec_count++;
    if ({saw, fetch_data} !== {1'b0, 8'h00}) begin
      err_count++;
      $display("FAIL rstmid_after: activity=%b fdata=%h required 0 00", saw, fetch_data);
    end
    $display("reset mid-access: done");
  endtask

`ifdef SPELL_MEM_CTRL_PREFETCH_EN
  task automatic test_prefetch();
    int s0;
    wait_cfg = 8'd0; rd_val = 8'hC3;
    fetch_addr = 8'hFF; fetch_req = 1'b1;
    tick(); tick();
    vec_count++;
    if ({fetch_ack, fetch_data} !== {1'b1, 8'hC3}) begin
      err_count++;
      $display("FAIL pf_first: ack=%b data=%h required 1 c3", fetch_ack, fetch_data);
    end
    fetch_req = 1'b0; rd_val = 8'hE1;
    tick(); tick();
    vec_count++;
    if ({mem_select, mem_addr, mem_type_data, mem_write} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      err_count++;
      $display("FAIL pf_spec: sel=%b addr=%h type=%b wr=%b required 1 00 0 0",
               mem_select, mem_addr, mem_type_data, mem_write);
    end
    tick();
    vec_count++;
    if (fetch_ack !== 1'b0) begin
      err_count++;
      $display("FAIL pf_noack: ack=%b required 0", fetch_ack);
    end
    tick();
    s0 = sel_cycles;
    fetch_addr = 8'h00; fetch_req = 1'b1;
    tick();
    vec_count++;
    if ({fetch_ack, fetch_data, mem_select} !== {1'b1, 8'hE1, 1'b0} || sel_cycles != s0) begin
      err_count++;
      $display("FAIL pf_hit: ack=%b data=%h sel=%b selcycles=%0d required 1 e1 0 0",
               fetch_ack, fetch_data, mem_select, sel_cycles - s0);
    end
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ls_req = 1'b1; ls_write = 1'b1; ls_code = 1'b1; ls_addr = 8'h01; ls_wdata = 8'h99;
    tick(); tick();
    ls_req = 1'b0; ls_write = 1'b0; ls_code = 1'b0;
    tick();
    rd_val = 8'h44; s0 = sel_cycles;
    fetch_addr = 8'h01; fetch_req = 1'b1;
    tick(); tick();
    vec_count++;
    if ({fetch_ack, fetch_data} !== {1'b1, 8'h44} || (sel_cycles - s0) != 1) begin
      err_count++;
      $display("FAIL pf_invalidate: ack=%b data=%h selcycles=%0d required 1 44 1",
               fetch_ack, fetch_data, sel_cycles - s0);
    end
    fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    $display("prefetch: hit 00, store 01 forced real fetch");
  endtask
`else
  task automatic test_no_prefetch();
    int s0;
    s0 = sel_cycles;
    wait_cfg = 8'd0; rd_val = 8'hC3;
    fetch_addr = 8'hFF; fetch_req = 1'b1;
    tick(); tick();
    fetch_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    vec_count++;
    if ({fetch_data, busy} !== {8'hC3, 1'b0} || (sel_cycles - s0) != 1) begin
      err_count++;
      $display("FAIL no_prefetch: data=%h busy=%b selcycles=%0d required c3 0 1",
               fetch_data, busy, sel_cycles - s0);
    end
    $display("fetch ff -> %h, no speculation", fetch_data);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_zero_wait();
    test_priority();
    test_wait_store();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid();
`ifdef SPELL_MEM_CTRL_PREFETCH_EN
    test_prefetch();
`else
    test_no_prefetch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
